// File: rtl/hs_pkg.sv
// Shared definitions for the handshake receive buffer:
// ready-return FSM encodings and a log2 helper for pointer widths.
package hs_pkg;

  localparam logic HS_IDLE = 1'b0;
  localparam logic HS_OWED = 1'b1;

  // Ceiling log2, used to size pointers from DEPTH
  function automatic int hs_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_rx_mem.sv
// Receive buffer storage: one synchronous write port,
// one asynchronous read port, contents not reset.
module hs_rx_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store the incoming word at the write address
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hs_rx_buffer.sv
// Destination-side receiver for the toggle-synchronised handshake:
// buffers pulsed words in a FIFO and returns one ready pulse per word.
module hs_rx_buffer
  import hs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [hs_log2(DEPTH):0]   level,
  output logic                      overflow,
  input  logic                      clr_overflow
);

  localparam int AW = hs_log2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic        state_q, state_d;
  logic        rdy_q, rdy_d;
  logic        ovf_q, ovf_d;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = in_valid & ~full;
  assign pop   = ~empty & out_ready;

  hs_rx_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (out_data)
  );

  // Next pointers and occupancy from this cycle's push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Ready-return: pay back each word now, or owe it until a pop
  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b0;
    unique case (state_q)
      HS_IDLE: begin
        if (push) begin
          if (level_d != FULL_LVL) rdy_d = 1'b1;
          else                     state_d = HS_OWED;
        end
      end
      HS_OWED: begin
        if (pop) begin
          rdy_d   = 1'b1;
          state_d = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  // Sticky overflow; a new drop wins over a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid & full) ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= HS_IDLE;
      rdy_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = ~empty;
  assign level     = level_q;
  assign overflow  = ovf_q;

endmodule
